// File: rtl/pipelined_cla_adder.sv
// pipelined_cla_adder
//   WIDTH-bit add/subtract split into STAGES carry-look-ahead segments, one
//   segment per pipeline stage. The carry between segments is registered, so
//   no carry path ever spans more than one segment. Segments 0..STAGES-2 are
//   WIDTH/STAGES bits wide and the last segment takes the remainder.
//
//   Every stage, including bubbles, moves forward when the output is empty or
//   being taken. Otherwise the whole pipe stalls, so in_ready equals that
//   advance condition.
//
//   Optional build macro PIPELINED_CLA_SAT_EN: when it is defined, r saturates
//   on signed overflow in the final stage. ovf and cout are unaffected.
//
// Ports
//   clk        system clock, rising edge
//   reset_n    asynchronous active-low reset
//   in_valid   operands present            in_ready   operands accepted this cycle
//   a, b       operands (WIDTH)            cin, sub   carry-in, 1 = a - b
//   out_valid  result present              out_ready  consumer takes result
//   r          sum / difference (WIDTH)    cout       carry out of MSB (1 = no borrow)
//   ovf        signed overflow
module pipelined_cla_adder #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] r,
    output logic             cout,
    output logic             ovf
);

    localparam int SEG     = WIDTH / STAGES;
    localparam int LAST_LO = (STAGES - 1) * SEG;
    localparam int LAST_W  = WIDTH - LAST_LO;

    logic             adv;
    logic [WIDTH-1:0] b_eff;
    logic             c0;

    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;
    assign b_eff    = sub ? ~b : b;
    assign c0       = sub ? ~cin : cin;

    // Stage k holds operand bits [WIDTH-1:LO] only. Its lowest SW bits are the
    // segment added in this stage. The rest are skewed on to later stages.
    // The low result bits already produced travel alongside in r_q.
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO = k * SEG;
        localparam int SW = (k == STAGES - 1) ? WIDTH - LO : SEG;
        localparam int UW = WIDTH - LO;

        logic          v_q, v_d;
        logic [UW-1:0] a_q, b_q, a_d, b_d;
        logic          c_q, c_d;
        logic [SW-1:0] g, p, s;
        logic [SW:0]   c;
        logic [LO+SW-1:0] nr;

        if (k == 0) begin : g_first
            assign v_d = in_valid;
            assign a_d = a;
            assign b_d = b_eff;
            assign c_d = c0;
            assign nr  = s;
        end else begin : g_next
            logic [LO-1:0] r_q;

            assign v_d = g_stage[k-1].v_q;
            assign a_d = g_stage[k-1].a_q[UW+SEG-1:SEG];
            assign b_d = g_stage[k-1].b_q[UW+SEG-1:SEG];
            assign c_d = g_stage[k-1].c[SEG];
            assign nr  = {s, r_q};

            always_ff @(posedge clk) begin
                if (adv) begin
                    r_q <= g_stage[k-1].nr;
                end
            end
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                v_q <= 1'b0;
            end else if (adv) begin
                v_q <= v_d;
            end
        end

        always_ff @(posedge clk) begin
            if (adv) begin
                a_q <= a_d;
                b_q <= b_d;
                c_q <= c_d;
            end
        end

        // Look-ahead carries: c[i+1] = G[i:0] | P[i:0] & c_q, expanded as a
        // flat sum of products rather than a ripple through c[i].
        always_comb begin
            logic cc;
            logic pp;
            g    = a_q[SW-1:0] & b_q[SW-1:0];
            p    = a_q[SW-1:0] ^ b_q[SW-1:0];
            c    = '0;
            c[0] = c_q;
            for (int i = 0; i < SW; i++) begin
                cc = 1'b0;
                pp = 1'b1;
                for (int j = i; j >= 0; j--) begin
                    cc = cc | (pp & g[j]);
                    pp = pp & p[j];
                end
                c[i+1] = cc | (pp & c_q);
            end
            s = p ^ c[SW-1:0];
        end
    end

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] r_d;
    logic             a_msb, b_msb, ovf_d;

    assign sum   = g_stage[STAGES-1].nr;
    assign a_msb = g_stage[STAGES-1].a_q[LAST_W-1];
    assign b_msb = g_stage[STAGES-1].b_q[LAST_W-1];
    assign ovf_d = (a_msb == b_msb) & (sum[WIDTH-1] != a_msb);

`ifdef PIPELINED_CLA_SAT_EN
    // Both operands share a sign on overflow, so a_msb gives the direction.
    always_comb begin
        r_d = sum;
        if (ovf_d) begin
            r_d = a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end
`else
    assign r_d = sum;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            r         <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
        end else if (adv) begin
            out_valid <= g_stage[STAGES-1].v_q;
            r         <= r_d;
            cout      <= g_stage[STAGES-1].c[LAST_W];
            ovf       <= ovf_d;
        end
    end

endmodule

// File: tb/tb_pipelined_cla_adder.sv
module tb_pipelined_cla_adder;

`ifdef PIPELINED_CLA_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef struct {
        logic [63:0] r;
        logic        co;
        logic        of;
        bit          lat;
        int          acc;
    } exp_t;

    localparam logic [15:0] DA [7] = '{16'h1234, 16'hFFFF, 16'h001F, 16'h0005, 16'h8000, 16'h7FFF, 16'h00FF};
    localparam logic [15:0] DB [7] = '{16'h4321, 16'h0001, 16'h0001, 16'h0007, 16'h0001, 16'h0001, 16'h0000};
    localparam bit          DS [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    localparam bit          DC [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    logic        clk;
    logic        rst_n;
    logic [2:0]  iv, cin_s, sub_s, ordy, irdy, ov, co, of;
    logic [63:0] ain [3];
    logic [63:0] bin [3];
    logic [15:0] r0;
    logic [31:0] r1;
    logic [7:0]  r2;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   stall_cnt = 0;
    bit [2:0] rbp = '0;
    exp_t q0[$], q1[$], q2[$];
    bit          held [3];
    logic [63:0] hold_r [3];

    pipelined_cla_adder #(.WIDTH(16), .STAGES(3)) u_d0 (
        .clk(clk), .reset_n(rst_n), .in_valid(iv[0]), .in_ready(irdy[0]),
        .a(ain[0][15:0]), .b(bin[0][15:0]), .cin(cin_s[0]), .sub(sub_s[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]), .r(r0), .cout(co[0]), .ovf(of[0]));

    pipelined_cla_adder #(.WIDTH(32), .STAGES(4)) u_d1 (
        .clk(clk), .reset_n(rst_n), .in_valid(iv[1]), .in_ready(irdy[1]),
        .a(ain[1][31:0]), .b(bin[1][31:0]), .cin(cin_s[1]), .sub(sub_s[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]), .r(r1), .cout(co[1]), .ovf(of[1]));

    pipelined_cla_adder #(.WIDTH(8), .STAGES(1)) u_d2 (
        .clk(clk), .reset_n(rst_n), .in_valid(iv[2]), .in_ready(irdy[2]),
        .a(ain[2][7:0]), .b(bin[2][7:0]), .cin(cin_s[2]), .sub(sub_s[2]),
        .out_valid(ov[2]), .out_ready(ordy[2]), .r(r2), .cout(co[2]), .ovf(of[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int wid(int i);
        return (i == 0) ? 16 : (i == 1) ? 32 : 8;
    endfunction

    function automatic int stg(int i);
        return (i == 0) ? 3 : (i == 1) ? 4 : 1;
    endfunction

    function automatic logic [63:0] getr(int i);
        if (i == 0) return {48'd0, r0};
        if (i == 1) return {32'd0, r1};
        return {56'd0, r2};
    endfunction

    // Reference: integer arithmetic on the operand values, signed overflow
    // judged by range of the true signed sum.
    function automatic exp_t model(int w, logic [63:0] av, logic [63:0] bv, logic c, logic s);
        logic [63:0] mask, be;
        logic        c0;
        logic [64:0] full;
        longint      sa, sb, sm, mx, mn;
        exp_t        e;
        mask = (64'd1 << w) - 64'd1;
        be   = (s ? ~bv : bv) & mask;
        c0   = s ? ~c : c;
        full = {1'b0, av & mask} + {1'b0, be} + {64'd0, c0};
        e.r  = full[63:0] & mask;
        e.co = full[w];
        sa = longint'(av & mask);
        if (av[w-1]) sa = sa - (longint'(1) << w);
        sb = longint'(be);
        if (be[w-1]) sb = sb - (longint'(1) << w);
        sm = sa + sb + (c0 ? 64'sd1 : 64'sd0);
        mx = (longint'(1) << (w - 1)) - 1;
        mn = -(longint'(1) << (w - 1));
        e.of = (sm > mx) || (sm < mn);
        if (SAT && e.of) e.r = (sm > mx) ? 64'(mx) : (64'(mn) & mask);
        e.lat = 1'b0;
        e.acc = 0;
        return e;
    endfunction

    function automatic int qsize(int i);
        if (i == 0) return q0.size();
        if (i == 1) return q1.size();
        return q2.size();
    endfunction

    function automatic void qpush(int i, exp_t e);
        if (i == 0) q0.push_back(e);
        else if (i == 1) q1.push_back(e);
        else q2.push_back(e);
    endfunction

    function automatic exp_t qpop(int i);
        if (i == 0) return q0.pop_front();
        if (i == 1) return q1.pop_front();
        return q2.pop_front();
    endfunction

    function automatic logic [63:0] rnd(int w);
        logic [63:0] m, v;
        m = (64'd1 << w) - 64'd1;
        case ($urandom_range(0, 7))
            0: v = m;
            1: v = 64'd0;
            2: v = 64'd1 << (w - 1);
            3: v = m >> 1;
            4: v = 64'd1;
            default: v = {$urandom, $urandom};
        endcase
        return v & m;
    endfunction

    task automatic chk(input string nm, input int i, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %0h expected %0h at cycle %0d", nm, i, got, exp, cyc);
        end
    endtask

    task automatic chk1(input string nm, input int i, input logic got, input logic exp);
        chk(nm, i, {63'd0, got}, {63'd0, exp});
    endtask

    task automatic fail(input string nm, input int i);
        checks++;
        errors++;
        $display("FAIL %s dut%0d: got timeout/extra expected none at cycle %0d", nm, i, cyc);
    endtask

    // Scoreboard monitor: compares at the falling edge, away from clk rise.
    always @(negedge clk) begin
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            if (!rst_n) begin
                held[i] = 1'b0;
            end else begin
                chk1("in_ready", i, irdy[i], ~ov[i] | ordy[i]);
                if (ov[i] && !ordy[i]) begin
                    if (held[i]) chk("stall_hold", i, getr(i), hold_r[i]);
                    held[i]   = 1'b1;
                    hold_r[i] = getr(i);
                end else begin
                    held[i] = 1'b0;
                end
                if (ov[i] && ordy[i]) begin
                    if (qsize(i) == 0) begin
                        fail("spurious_output", i);
                    end else begin
                        e = qpop(i);
                        chk("r", i, getr(i), e.r);
                        chk1("cout", i, co[i], e.co);
                        chk1("ovf", i, of[i], e.of);
                        if (e.lat) chk("latency", i, 64'(cyc - e.acc), 64'(stg(i)));
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (stall_cnt > 0) begin
            stall_cnt--;
            if (stall_cnt == 0) ordy[0] = 1'b1;
        end
        for (int i = 0; i < 3; i++) begin
            if (rbp[i]) ordy[i] = ($urandom_range(0, 3) != 0);
        end
    endtask

    task automatic send(input int i, input logic [63:0] av, input logic [63:0] bv,
                        input logic c, input logic s, input bit lat);
        exp_t e;
        bit   done;
        int   n;
        ain[i] = av; bin[i] = bv; cin_s[i] = c; sub_s[i] = s; iv[i] = 1'b1;
        done = 1'b0;
        n = 0;
        while (!done) begin
            @(negedge clk);
            if (irdy[i]) begin
                e = model(wid(i), av, bv, c, s);
                e.lat = lat;
                e.acc = cyc + 1;
                qpush(i, e);
                done = 1'b1;
            end
            tick();
            n++;
            if (!done && n > 200) begin
                fail("accept_timeout", i);
                done = 1'b1;
            end
        end
        iv[i] = 1'b0;
    endtask

    task automatic drain(input int i);
        int n;
        rbp[i] = 1'b0;
        ordy[i] = 1'b1;
        n = 0;
        while (qsize(i) != 0 && n < 100) begin
            tick();
            n++;
        end
        if (qsize(i) != 0) fail("drain_timeout", i);
        repeat (3) tick();
    endtask

    task automatic run_random(input int i, input int nops);
        int w;
        w = wid(i);
        for (int k = 0; k < nops; k++) begin
            if (k == (nops * 2) / 5) begin
                drain(i);
                rbp[i] = 1'b1;
            end
            if ($urandom_range(0, 3) == 0) tick();
            send(i, rnd(w), rnd(w), $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, !rbp[i]);
        end
        drain(i);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b1;
        iv = '0; cin_s = '0; sub_s = '0; ordy = 3'b111;
        for (int i = 0; i < 3; i++) begin
            ain[i] = '0;
            bin[i] = '0;
        end
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk1("rst_out_valid", i, ov[i], 1'b0);
            chk("rst_r", i, getr(i), 64'd0);
            chk1("rst_cout", i, co[i], 1'b0);
            chk1("rst_ovf", i, of[i], 1'b0);
        end
        #20;
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        // Directed cases, output always ready so latency is exact.
        for (int k = 0; k < 7; k++) begin
            send(0, {48'd0, DA[k]}, {48'd0, DB[k]}, DC[k], DS[k], 1'b1);
        end
        drain(0);

        // Six back-to-back ops with a four-cycle output stall mid-stream.
        for (int k = 0; k < 6; k++) begin
            send(0, rnd(16), rnd(16), $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 1'b0);
            if (k == 2) begin
                ordy[0] = 1'b0;
                stall_cnt = 4;
            end
        end
        drain(0);

        // Reset with two ops in flight.
        send(0, 64'h0000_0000_0000_1111, 64'h0000_0000_0000_2222, 1'b0, 1'b0, 1'b0);
        send(0, 64'h0000_0000_0000_3333, 64'h0000_0000_0000_4444, 1'b1, 1'b0, 1'b0);
        tick();
        rst_n = 1'b0;
        #1;
        chk1("midrst_out_valid", 0, ov[0], 1'b0);
        chk("midrst_r", 0, getr(0), 64'd0);
        chk1("midrst_cout", 0, co[0], 1'b0);
        chk1("midrst_ovf", 0, of[0], 1'b0);
        q0.delete();
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            chk1("no_stale", 0, ov[0], 1'b0);
            tick();
        end
        send(0, 64'h0000_0000_0000_0F0F, 64'h0000_0000_0000_00F1, 1'b0, 1'b0, 1'b1);
        drain(0);

        run_random(0, 300);
        run_random(1, 1000);
        run_random(2, 1000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
